// File: rtl/rs_age_select_pkg.sv
// Shared types for the age-ordered reservation station.
//   TAG            physical register tag carried on the CDB
//   SRC_TAG        one source operand: valid (operand exists), ready, phys_reg
//   DECODER_PACKET instruction as delivered by ID; rs_idx is filled on issue
//   RS_ENTRY_T     one reservation-station slot {busy, issued, packet}
// rs_idx is RS_IDX_W bits wide, which covers RS_DEPTH up to 16.
package rs_age_select_pkg;

  localparam int PREG_W   = 6;
  localparam int RS_IDX_W = 4;

  typedef logic [PREG_W-1:0] TAG;

  typedef struct packed {
    logic valid;
    logic ready;
    TAG   phys_reg;
  } SRC_TAG;

  typedef struct packed {
    logic [7:0]          opcode;
    TAG                  dest;
    SRC_TAG              t1;
    SRC_TAG              t2;
    logic [RS_IDX_W-1:0] rs_idx;
  } DECODER_PACKET;

  typedef struct packed {
    logic          busy;
    logic          issued;
    DECODER_PACKET packet;
  } RS_ENTRY_T;

  // An operand stops blocking issue once it is absent or already ready.
  function automatic logic src_ok(SRC_TAG s);
    return !s.valid || s.ready;
  endfunction

endpackage

// File: rtl/rs_age_select_if.sv
// Dispatch / wakeup / issue / release bundle of the reservation station.
//   master : the pipeline side (ID, CDB, IS, EX) that drives requests
//   slave  : the reservation station itself
// Signals: squash, dispatch_en/packet/ready, free_count, cdb_en/tag,
//          issue_stall/valid/packet/idx, release_en/idx.
interface rs_age_select_if #(
  parameter int RS_DEPTH  = 8,
  parameter int CDB_WIDTH = 2
);
  import rs_age_select_pkg::*;

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic                    squash;
  logic                    dispatch_en;
  DECODER_PACKET           dispatch_packet;
  logic                    dispatch_ready;
  logic [IDX_W:0]          free_count;
  logic [CDB_WIDTH-1:0]    cdb_en;
  TAG   [CDB_WIDTH-1:0]    cdb_tag;
  logic                    issue_stall;
  logic                    issue_valid;
  DECODER_PACKET           issue_packet;
  logic [IDX_W-1:0]        issue_idx;
  logic                    release_en;
  logic [IDX_W-1:0]        release_idx;

  modport master (
    output squash, dispatch_en, dispatch_packet, cdb_en, cdb_tag,
           issue_stall, release_en, release_idx,
    input  dispatch_ready, free_count, issue_valid, issue_packet, issue_idx
  );

  modport slave (
    input  squash, dispatch_en, dispatch_packet, cdb_en, cdb_tag,
           issue_stall, release_en, release_idx,
    output dispatch_ready, free_count, issue_valid, issue_packet, issue_idx
  );

endinterface

// File: rtl/rs_age_select_age_matrix.sv
// Age matrix for oldest-first selection among RS_DEPTH entries.
// age_q[i][j] = 1 means entry j is older than entry i.
//   clock, clear     : clock and synchronous active-high clear (reset or squash)
//   alloc_en/idx     : entry being written this cycle
//   busy             : current busy vector (becomes the new entry's row)
//   eligible         : entries ready to issue this cycle
//   grant_valid/idx  : the single oldest eligible entry
module rs_age_select_age_matrix #(
  parameter  int RS_DEPTH = 8,
  localparam int IDX_W    = $clog2(RS_DEPTH)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                alloc_en,
  input  logic [IDX_W-1:0]    alloc_idx,
  input  logic [RS_DEPTH-1:0] busy,
  input  logic [RS_DEPTH-1:0] eligible,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] win;

  // A new entry is younger than everything currently busy. Clearing its
  // column wipes stale "older" marks left by the previous occupant, so
  // rows of freed entries never need scrubbing.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int r = 0; r < RS_DEPTH; r++) age_q[r] <= '0;
    end else if (alloc_en) begin
      for (int r = 0; r < RS_DEPTH; r++) age_q[r][alloc_idx] <= 1'b0;
      age_q[alloc_idx] <= busy;
    end
  end

  // Ages form a strict total order over busy entries, so at most one
  // eligible entry has no eligible elder.
  always_comb begin
    win         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      win[i] = eligible[i] && ((age_q[i] & eligible) == '0);
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (win[i] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_age_select.sv
// Reservation station with RS_DEPTH generic entries, CDB_WIDTH wakeup ports
// and oldest-first issue. Sits between ID (dispatch) and IS (issue); EX frees
// entries through release_en/release_idx.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : rs_age_select_if.slave (dispatch, CDB, issue, release, squash)
// Build option RS_CDB_BYPASS_EN: when defined, a CDB hit in the current cycle
// counts as ready for eligibility (0-cycle wakeup); otherwise only the stored
// ready bit counts and issue follows the broadcast by one cycle.
module rs_age_select
  import rs_age_select_pkg::*;
#(
  parameter int RS_DEPTH  = 8,
  parameter int CDB_WIDTH = 2
) (
  input logic           clock,
  input logic           reset,
  rs_age_select_if.slave bus
);

  localparam int             IDX_W   = $clog2(RS_DEPTH);
  localparam logic [IDX_W:0] CNT_ONE = 1;

  RS_ENTRY_T           rs_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy_vec;
  logic [RS_DEPTH-1:0] eligible_vec;
  logic [RS_DEPTH-1:0] t1_hit;
  logic [RS_DEPTH-1:0] t2_hit;
  logic [IDX_W-1:0]    alloc_idx;
  logic                alloc_found;
  logic                alloc_en;
  logic [IDX_W:0]      free_cnt;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic                fire;
  logic                clear;
  logic                disp_t1_hit;
  logic                disp_t2_hit;
  DECODER_PACKET       disp_pkt;
  DECODER_PACKET       issue_pkt;

  function automatic logic cdb_match(TAG tag, logic [CDB_WIDTH-1:0] en,
                                     TAG [CDB_WIDTH-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_WIDTH; p++) begin
      if (en[p] && tags[p] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  assign clear = reset | bus.squash;

  // Per-entry CDB compare and eligibility.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    busy_vec     = '0;
    eligible_vec = '0;
    t1_hit       = '0;
    t2_hit       = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_vec[i] = rs_q[i].busy;
      t1_hit[i]   = cdb_match(rs_q[i].packet.t1.phys_reg, bus.cdb_en, bus.cdb_tag);
      t2_hit[i]   = cdb_match(rs_q[i].packet.t2.phys_reg, bus.cdb_en, bus.cdb_tag);
`ifdef RS_CDB_BYPASS_EN
      eligible_vec[i] = rs_q[i].busy && !rs_q[i].issued &&
                        (src_ok(rs_q[i].packet.t1) || t1_hit[i]) &&
                        (src_ok(rs_q[i].packet.t2) || t2_hit[i]);
`else
      eligible_vec[i] = rs_q[i].busy && !rs_q[i].issued &&
                        src_ok(rs_q[i].packet.t1) && src_ok(rs_q[i].packet.t2);
`endif
    end
  end

  // Lowest free index and free-entry popcount, both from registered busy
  // only, so dispatch_ready has no path from dispatch_en.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    free_cnt    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_vec[i]) begin
        free_cnt = free_cnt + CNT_ONE;
        if (!alloc_found) begin
          alloc_found = 1'b1;
          alloc_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign alloc_en           = bus.dispatch_en && alloc_found;
  assign bus.dispatch_ready = alloc_found;
  assign bus.free_count     = free_cnt;

  // Capture a broadcast that lands in the dispatch cycle so it is not lost.
  always_comb begin
    disp_t1_hit = cdb_match(bus.dispatch_packet.t1.phys_reg, bus.cdb_en, bus.cdb_tag);
    disp_t2_hit = cdb_match(bus.dispatch_packet.t2.phys_reg, bus.cdb_en, bus.cdb_tag);
    disp_pkt    = bus.dispatch_packet;
    if (disp_pkt.t1.valid && disp_t1_hit) disp_pkt.t1.ready = 1'b1;
    if (disp_pkt.t2.valid && disp_t2_hit) disp_pkt.t2.ready = 1'b1;
    disp_pkt.rs_idx = RS_IDX_W'(alloc_idx);
  end

  rs_age_select_age_matrix #(.RS_DEPTH(RS_DEPTH)) u_age (
    .clock       (clock),
    .clear       (clear),
    .alloc_en    (alloc_en),
    .alloc_idx   (alloc_idx),
    .busy        (busy_vec),
    .eligible    (eligible_vec),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    issue_pkt        = rs_q[grant_idx].packet;
    issue_pkt.rs_idx = RS_IDX_W'(grant_idx);
  end

  assign bus.issue_valid  = grant_valid;
  assign bus.issue_idx    = grant_idx;
  assign bus.issue_packet = issue_pkt;
  assign fire             = grant_valid && !bus.issue_stall;

  // Within one entry the later assignment wins: issue, then release, then
  // allocation (allocation only targets a non-busy entry, so it never
  // collides with release or issue).
  // NOTE: only busy/issued are reset; the payload is qualified by busy and
  // is simply overwritten on allocation, so it carries no reset.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        rs_q[i].busy   <= 1'b0;
        rs_q[i].issued <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        // NOTE: non-blocking assignments here, so every entry sees the
        // pre-edge state regardless of loop order.
        if (rs_q[i].busy) begin
          if (rs_q[i].packet.t1.valid && t1_hit[i]) rs_q[i].packet.t1.ready <= 1'b1;
          if (rs_q[i].packet.t2.valid && t2_hit[i]) rs_q[i].packet.t2.ready <= 1'b1;
        end
        if (fire && grant_idx == IDX_W'(i)) rs_q[i].issued <= 1'b1;
        if (bus.release_en && bus.release_idx == IDX_W'(i) && rs_q[i].busy) begin
          rs_q[i].busy   <= 1'b0;
          rs_q[i].issued <= 1'b0;
        end
        if (alloc_en && alloc_idx == IDX_W'(i)) begin
          rs_q[i].busy   <= 1'b1;
          rs_q[i].issued <= 1'b0;
          rs_q[i].packet <= disp_pkt;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_select.sv
// Scoreboard bench for rs_age_select (RS_DEPTH=8, CDB_WIDTH=2).
// Stimulus pushes the expected issue order into sb_q; a negedge monitor pops
// and compares on every fired issue. Cycle-exact expectations follow the
// RS_CDB_BYPASS_EN setting.
module tb_rs_age_select;
  import rs_age_select_pkg::*;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] opcode;
    SRC_TAG     t2;
  } exp_t;

  logic   clock;
  logic   reset;
  exp_t   sb_q[$];
  int     vectors     = 0;
  int     miscompares = 0;
  SRC_TAG none_src;

  rs_age_select_if #(.RS_DEPTH(8), .CDB_WIDTH(2)) bus ();

  rs_age_select #(.RS_DEPTH(8), .CDB_WIDTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic SRC_TAG src(input logic v, input logic r, input int p);
    SRC_TAG s;
    s.valid    = v;
    s.ready    = r;
    s.phys_reg = TAG'(p);
    return s;
  endfunction

  function automatic DECODER_PACKET mk_pkt(input logic [7:0] op, input SRC_TAG t1,
                                           input SRC_TAG t2);
    DECODER_PACKET p;
    p        = '0;
    p.opcode = op;
    p.dest   = TAG'(op);
    p.t1     = t1;
    p.t2     = t2;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.squash          = 1'b0;
    bus.dispatch_en     = 1'b0;
    bus.dispatch_packet = '0;
    bus.cdb_en          = '0;
    bus.cdb_tag         = '0;
    bus.release_en      = 1'b0;
    bus.release_idx     = '0;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.issue_stall = 1'b0;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic dispatch(input DECODER_PACKET p);
    bus.dispatch_en     = 1'b1;
    bus.dispatch_packet = p;
    tick();
    bus.dispatch_en     = 1'b0;
  endtask

  task automatic release_entry(input int idx);
    bus.release_en  = 1'b1;
    bus.release_idx = 3'(idx);
    tick();
    bus.release_en  = 1'b0;
  endtask

  task automatic expect_issue(input int idx, input DECODER_PACKET p);
    exp_t e;
    e.idx    = 3'(idx);
    e.opcode = p.opcode;
    e.t2     = p.t2;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) tick();
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every fired issue must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.issue_valid === 1'b1 && bus.issue_stall === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_issue_sb_depth", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("issue_idx",    32'(bus.issue_idx),           32'(e.idx));
        check("issue_opcode", 32'(bus.issue_packet.opcode), 32'(e.opcode));
        check("issue_rs_idx", 32'(bus.issue_packet.rs_idx), 32'(e.idx));
        check("issue_t2",     32'(bus.issue_packet.t2),     32'(e.t2));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    DECODER_PACKET p, a, b;
    none_src = src(1'b0, 1'b0, 0);
    reset    = 1'b1;

    // Reset state.
    do_reset();
    check("rst_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
    check("rst_free_count",     32'(bus.free_count),     32'd8);
    check("rst_issue_valid",    32'(bus.issue_valid),    32'd0);

    // 1: eight source-free dispatches fill 0..7 in order and issue in order.
    for (int i = 0; i < 8; i++) begin
      p = mk_pkt(8'(8'h10 + i), none_src, none_src);
      expect_issue(i, p);
      dispatch(p);
    end
    check("t1_full_ready", 32'(bus.dispatch_ready), 32'd0);
    check("t1_full_count", 32'(bus.free_count),     32'd0);
    dispatch(mk_pkt(8'hFF, none_src, none_src));
    check("t1_ninth_ready", 32'(bus.dispatch_ready), 32'd0);
    check("t1_ninth_count", 32'(bus.free_count),     32'd0);
    drain("t1_drain");
    check("t1_all_issued", 32'(bus.issue_valid), 32'd0);

    // 2: A waits on P5, B is ready; B issues first, A after broadcast on port 1.
    do_reset();
    a = mk_pkt(8'h20, src(1'b1, 1'b0, 5), none_src);
    b = mk_pkt(8'h21, none_src, none_src);
    expect_issue(1, b);
    expect_issue(0, a);
    dispatch(a);
    dispatch(b);
    check("t2_b_first_idx", 32'(bus.issue_idx), 32'd1);
    tick();
    bus.cdb_en     = 2'b10;
    bus.cdb_tag[1] = TAG'(5);
    bus.cdb_tag[0] = TAG'(7);
    #1;
`ifdef RS_CDB_BYPASS_EN
    check("t2_bcast_cycle_valid", 32'(bus.issue_valid), 32'd1);
    check("t2_bcast_cycle_idx",   32'(bus.issue_idx),   32'd0);
    tick();
    check("t2_after_bcast_valid", 32'(bus.issue_valid), 32'd0);
`else
    check("t2_bcast_cycle_valid", 32'(bus.issue_valid), 32'd0);
    tick();
    check("t2_after_bcast_valid", 32'(bus.issue_valid), 32'd1);
    check("t2_after_bcast_idx",   32'(bus.issue_idx),   32'd0);
`endif
    idle();
    drain("t2_drain");

    // 3: idx 3 older than idx 1; stall holds 3; releasing 3 hands issue to 1.
    do_reset();
    bus.issue_stall = 1'b1;
    for (int k = 0; k < 4; k++) dispatch(mk_pkt(8'(8'h30 + k), src(1'b1, 1'b0, 30), none_src));
    release_entry(3);
    dispatch(mk_pkt(8'h3C, none_src, none_src));
    check("t3_free_count", 32'(bus.free_count), 32'd4);
    release_entry(1);
    b = mk_pkt(8'h3D, none_src, none_src);
    dispatch(b);
    for (int s = 0; s < 2; s++) begin
      check("t3_stall_valid",  32'(bus.issue_valid),         32'd1);
      check("t3_stall_idx",    32'(bus.issue_idx),           32'd3);
      check("t3_stall_opcode", 32'(bus.issue_packet.opcode), 32'h3C);
      tick();
    end
    release_entry(3);
    check("t3_after_rel_idx",    32'(bus.issue_idx),           32'd1);
    check("t3_after_rel_opcode", 32'(bus.issue_packet.opcode), 32'h3D);
    expect_issue(1, b);
    bus.issue_stall = 1'b0;
    drain("t3_drain");
    check("t3_waiters_idle", 32'(bus.issue_valid), 32'd0);

    // 4: broadcast of P9 in the dispatch cycle is captured as ready.
    do_reset();
    p = mk_pkt(8'h40, src(1'b1, 1'b0, 9), none_src);
    expect_issue(0, p);
    bus.cdb_en     = 2'b01;
    bus.cdb_tag[0] = TAG'(9);
    bus.cdb_tag[1] = TAG'(3);
    dispatch(p);
    check("t4_capture_valid", 32'(bus.issue_valid),           32'd1);
    check("t4_capture_idx",   32'(bus.issue_idx),             32'd0);
    check("t4_capture_ready", 32'(bus.issue_packet.t1.ready), 32'd1);
    idle();
    drain("t4_drain");

    // 5: invalid t2 with phys_reg P4 is untouched by a P4 broadcast.
    do_reset();
    p = mk_pkt(8'h50, src(1'b1, 1'b0, 12), src(1'b0, 1'b0, 4));
    expect_issue(0, p);
    dispatch(p);
    bus.cdb_en     = 2'b01;
    bus.cdb_tag[0] = TAG'(4);
    #1;
    check("t5_p4_no_issue", 32'(bus.issue_valid), 32'd0);
    tick();
    check("t5_p4_after_no_issue", 32'(bus.issue_valid), 32'd0);
    bus.cdb_tag[0] = TAG'(12);
    #1;
`ifdef RS_CDB_BYPASS_EN
    check("t5_p12_valid", 32'(bus.issue_valid), 32'd1);
    tick();
`else
    check("t5_p12_valid", 32'(bus.issue_valid), 32'd0);
    tick();
    check("t5_p12_next_valid", 32'(bus.issue_valid), 32'd1);
`endif
    idle();
    drain("t5_drain");

    // 6: squash beats dispatch, release and wakeup in the same cycle.
    do_reset();
    for (int k = 0; k < 5; k++) dispatch(mk_pkt(8'(8'h60 + k), src(1'b1, 1'b0, 30), none_src));
    check("t6_pre_free_count", 32'(bus.free_count), 32'd3);
    bus.squash          = 1'b1;
    bus.dispatch_en     = 1'b1;
    bus.dispatch_packet = mk_pkt(8'h66, none_src, none_src);
    bus.release_en      = 1'b1;
    bus.release_idx     = 3'd2;
    bus.cdb_en          = 2'b01;
    bus.cdb_tag[0]      = TAG'(30);
    tick();
    idle();
    check("t6_free_count",     32'(bus.free_count),     32'd8);
    check("t6_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
    check("t6_issue_valid",    32'(bus.issue_valid),    32'd0);
    bus.cdb_en     = 2'b01;
    bus.cdb_tag[0] = TAG'(30);
    tick();
    idle();
    check("t6_no_alloc_count", 32'(bus.free_count),  32'd8);
    check("t6_no_alloc_valid", 32'(bus.issue_valid), 32'd0);

    drain("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
